// File: rtl/decoder_round_driver.sv
// Host-side round initiator: accepts a syndrome frame, pulses the controller start,
// waits for result/deadlock/watchdog, and emits one tagged result record per round.
module decoder_round_driver #(
   parameter int unsigned CODE_DISTANCE_X         = 4,
   parameter int unsigned CODE_DISTANCE_Z         = 12,
   parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
   parameter int unsigned ROUND_ID_WIDTH          = 8,
   parameter int unsigned START_MASK_CYCLES       = 2,
   parameter int unsigned TIMEOUT_CYCLES          = 65535,
   localparam int unsigned D_MAX    = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                      CODE_DISTANCE_X : CODE_DISTANCE_Z,
   localparam int unsigned PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * D_MAX
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               syndrome_valid,
   output logic                               syndrome_ready,
   input  logic [PU_COUNT-1:0]                syndrome_data,
   output logic [PU_COUNT-1:0]                measurements,
   output logic                               new_round_start,
   input  logic                               result_valid,
   input  logic                               deadlock,
   input  logic                               final_cardinality,
   input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
   input  logic [31:0]                        cycle_counter,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [ROUND_ID_WIDTH-1:0]          out_round_id,
   output logic                               out_cardinality,
   output logic [ITERATION_COUNTER_WIDTH-1:0] out_iterations,
   output logic [31:0]                        out_cycles,
   output logic [1:0]                         out_status,
   output logic                               busy
);

   localparam int unsigned MaskW = $clog2(START_MASK_CYCLES + 1);
   localparam int unsigned WdW   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] StatusOk       = 2'b00;
   localparam logic [1:0] StatusDeadlock = 2'b01;
   localparam logic [1:0] StatusTimeout  = 2'b10;

   typedef enum logic [2:0] {StIdle, StStart, StMask, StWait, StOutput} state_e;

   state_e                    state_q, state_d;
   logic [MaskW-1:0]          mask_cnt_q;
   logic [WdW-1:0]            wd_q;
   logic [ROUND_ID_WIDTH-1:0] round_id_q;
   logic                      capture;
   logic [1:0]                status_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      syndrome_ready = 1'b0;
      busy           = 1'b1;
      capture        = 1'b0;
      status_d       = StatusOk;
      unique case (state_q)
         StIdle: begin
            syndrome_ready = 1'b1;
            busy           = 1'b0;
            if (syndrome_valid) state_d = StStart;
         end
         StStart: state_d = StMask;
         StMask: begin
            if (mask_cnt_q == MaskW'(1)) state_d = StWait;
         end
         StWait: begin
            // Fixed priority: result beats deadlock beats watchdog.
            if (result_valid) begin
               capture  = 1'b1;
               status_d = StatusOk;
            end else if (deadlock) begin
               capture  = 1'b1;
               status_d = StatusDeadlock;
            end else if (wd_q == WdW'(TIMEOUT_CYCLES)) begin
               capture  = 1'b1;
               status_d = StatusTimeout;
            end
            if (capture) state_d = StOutput;
         end
         StOutput: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         measurements    <= '0;
         new_round_start <= 1'b0;
         mask_cnt_q      <= '0;
         wd_q            <= '0;
         round_id_q      <= '0;
         out_valid       <= 1'b0;
         out_round_id    <= '0;
         out_cardinality <= 1'b0;
         out_iterations  <= '0;
         out_cycles      <= '0;
         out_status      <= '0;
      end else begin
         new_round_start <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (syndrome_valid) begin
                  measurements    <= syndrome_data;
                  new_round_start <= 1'b1;
               end
            end
            StStart: begin
               mask_cnt_q <= MaskW'(START_MASK_CYCLES);
               wd_q       <= '0;
            end
            StMask: mask_cnt_q <= mask_cnt_q - MaskW'(1);
            StWait: begin
               if (capture) begin
                  out_valid    <= 1'b1;
                  out_round_id <= round_id_q;
                  out_status   <= status_d;
                  out_cycles   <= cycle_counter;
                  if (status_d == StatusTimeout) begin
                     out_cardinality <= 1'b0;
                     out_iterations  <= '0;
                  end else begin
                     out_cardinality <= final_cardinality;
                     out_iterations  <= iteration_counter;
                  end
               end else begin
                  wd_q <= wd_q + WdW'(1);
               end
            end
            StOutput: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  round_id_q <= round_id_q + ROUND_ID_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/decoder_round_driver.md
Name: decoder_round_driver

Overview:
Host-side initiator for the decoder stage controller. Accepts one syndrome frame per round over a valid/ready stream and presents it on the measurement bus. Issues the single-cycle new_round_start, then waits for the controller's result_valid or deadlock, or for a local watchdog timeout. Emits one tagged result record per round over a valid/ready output stream.

Parameters:
CODE_DISTANCE_X, 4, code distance X
CODE_DISTANCE_Z, 12, code distance Z
ITERATION_COUNTER_WIDTH, 8, width of the controller iteration count
ROUND_ID_WIDTH, 8, width of the round tag; wraps modulo 2^ROUND_ID_WIDTH
START_MASK_CYCLES, 2, cycles after the start pulse during which result_valid and deadlock are ignored; legal range >=1
TIMEOUT_CYCLES, 65535, watchdog limit in WAIT; counter width is $clog2(TIMEOUT_CYCLES+1)
Derived: PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * max(CODE_DISTANCE_X, CODE_DISTANCE_Z)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
syndrome_valid  in  1  input frame valid
syndrome_ready  out  1  driver can accept a frame
syndrome_data  in  PU_COUNT  one bit per PU
measurements  out  PU_COUNT  registered frame, held stable until the next accept
new_round_start  out  1  one-cycle start pulse to the controller
result_valid  in  1  controller result ready (level)
deadlock  in  1  controller deadlock flag (level)
final_cardinality  in  1  controller result bit
iteration_counter  in  ITERATION_COUNTER_WIDTH  controller iteration count
cycle_counter  in  32  controller cycle count
out_valid  out  1  result record valid
out_ready  in  1  downstream accepts the record
out_round_id  out  ROUND_ID_WIDTH  round tag
out_cardinality  out  1  captured final_cardinality
out_iterations  out  ITERATION_COUNTER_WIDTH  captured iteration count
out_cycles  out  32  captured cycle count
out_status  out  2  00 ok, 01 deadlock, 10 timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE. All outputs 0, except syndrome_ready = 1 (IDLE is combinational from state). Round id 0, mask counter 0, watchdog 0. Reset in any state aborts the round: no pulse, no record, in-flight record dropped.
- States: IDLE, START, MASK, WAIT, OUTPUT.
- IDLE: syndrome_ready = 1. On syndrome_valid && ready, register syndrome_data into measurements and go to START. Otherwise stay.
- START: new_round_start = 1 for exactly this cycle (registered output, asserted the cycle after accept). Load the mask counter, clear the watchdog, go to MASK.
- MASK: ignore result_valid and deadlock, because the previous round's flags stay high until the controller samples the start. Stay exactly START_MASK_CYCLES cycles, then go to WAIT.
- WAIT: the watchdog increments each cycle. Checks have fixed priority:
  - result_valid = 1: capture final_cardinality, iteration_counter, cycle_counter; status 00.
  - else deadlock = 1: capture the same fields; status 01.
  - else watchdog == TIMEOUT_CYCLES: capture cardinality 0, iterations 0, cycles = cycle_counter; status 10.
  - On any capture, load out_round_id with the current id, set out_valid = 1, go to OUTPUT.
- OUTPUT: out_* fields held stable while out_valid && !out_ready. On out_valid && out_ready: out_valid = 0, round id increments (wraps), go to IDLE. No new frame is accepted in the handshake cycle; earliest next accept is the following cycle.
- syndrome_ready = 0 and measurements unchanged in START, MASK, WAIT, OUTPUT.
- Controller inputs are sampled only in WAIT; changes in other states have no effect.
- Minimum round latency: accept at T, pulse at T+1, earliest capture at T+2+START_MASK_CYCLES, out_valid at T+3+START_MASK_CYCLES.

Test Plan:
- Reset, then frame with bit0 = 1 accepted at T -> measurements bit0 = 1 from T+1; new_round_start high only at T+1. Controller model raises result_valid at T+10 with cardinality 1, iterations 3, cycles 42 -> out_valid at T+11 with id 0, status 00, 1/3/42.
- result_valid held high from the previous round through cycles T+1..T+3 (START_MASK_CYCLES = 2) -> not captured. Drop it at T+3, re-raise at T+8 -> record at T+9.
- deadlock = 1 and result_valid = 0 in WAIT -> status 01. Both high in the same cycle -> status 00 (priority).
- TIMEOUT_CYCLES = 20, controller silent -> status 10, iterations 0, exactly 20 WAIT cycles counted.
- out_ready held low 5 cycles -> record stable, syndrome_ready = 0. After 256 rounds, round id wraps 255 -> 0.
- Reset asserted mid-WAIT -> next cycle IDLE, out_valid = 0, round id 0, no spurious new_round_start.
